// File: rtl/branch_predictor_gshare.sv
// branch_predictor_gshare: tagged direct-mapped BTB plus bimodal/gshare PHT direction predictor
//   CLK, RST (async, active-high)           clock and reset
//   mode_gshare                             0 = PHT indexed by PC, 1 = PC xor global history
//   IF_PC -> pred_taken, pred_target        combinational fetch lookup
//   flush_all                               invalidate all BTB entries, drops a coincident update
//   upd_*                                   resolved branch training from EX
//   perf_updates, perf_mispred              saturating event counters
module branch_predictor_gshare #(
  parameter int PC_W     = 12,
  parameter int IDX_W    = 4,
  parameter int CNT_W    = 2,
  parameter int GHR_W    = 4,
  parameter int INIT_CNT = 1,
  parameter int PERF_W   = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              mode_gshare,
  input  logic [PC_W-1:0]   IF_PC,
  output logic              pred_taken,
  output logic [PC_W-1:0]   pred_target,
  input  logic              flush_all,
  input  logic              upd_valid,
  input  logic [PC_W-1:0]   upd_pc,
  input  logic              upd_taken,
  input  logic [PC_W-1:0]   upd_target,
  input  logic              upd_mispredict,
  output logic [PERF_W-1:0] perf_updates,
  output logic [PERF_W-1:0] perf_mispred
);
  localparam int N     = 2 ** IDX_W;
  localparam int TAG_W = PC_W - IDX_W;
  logic [N-1:0]       valid;
  logic [TAG_W-1:0]   tag_tbl [N];
  logic [PC_W-1:0]    tgt_tbl [N];
  logic [CNT_W-1:0]   pht [N];
  logic [GHR_W-1:0]   ghr;
  logic [IDX_W-1:0]   if_idx, if_pht_idx, up_idx, up_pht_idx, hist;
  logic [CNT_W-1:0]   cnt;
  logic               hit, do_upd;
  assign hist        = mode_gshare ? IDX_W'(ghr) : '0;
  assign if_idx      = IF_PC[IDX_W-1:0];
  assign up_idx      = upd_pc[IDX_W-1:0];
  assign if_pht_idx  = if_idx ^ hist;
  assign up_pht_idx  = up_idx ^ hist;
  assign hit         = valid[if_idx] && (tag_tbl[if_idx] == IF_PC[PC_W-1:IDX_W]);
  assign pred_taken  = hit && pht[if_pht_idx][CNT_W-1];
  assign pred_target = pred_taken ? tgt_tbl[if_idx] : '0;
  assign do_upd      = upd_valid && !flush_all;
  assign cnt         = pht[up_pht_idx];
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid        <= '0;
      ghr          <= '0;
      perf_updates <= '0;
      perf_mispred <= '0;
      for (int i = 0; i < N; i++) pht[i] <= CNT_W'(INIT_CNT);
    end else if (flush_all) begin
      valid <= '0;
    end else if (upd_valid) begin
      pht[up_pht_idx] <= upd_taken ? (&cnt ? cnt : cnt + CNT_W'(1))
                                   : (|cnt ? cnt - CNT_W'(1) : cnt);
      if (upd_taken) valid[up_idx] <= 1'b1;
      // truncating {ghr, taken} keeps the newest GHR_W bits, valid for any GHR_W >= 1
      ghr <= GHR_W'({ghr, upd_taken});
      if (!(&perf_updates)) perf_updates <= perf_updates + PERF_W'(1);
      if (upd_mispredict && !(&perf_mispred)) perf_mispred <= perf_mispred + PERF_W'(1);
    end
  end
  // tag/target storage needs no reset: entries are only read behind a valid bit
  always_ff @(posedge CLK) begin
    if (do_upd && upd_taken) begin
      tag_tbl[up_idx] <= upd_pc[PC_W-1:IDX_W];
      tgt_tbl[up_idx] <= upd_target;
    end
  end
endmodule

// File: tb/tb_branch_predictor_gshare.sv
// tb_branch_predictor_gshare: directed checks of lookup, training, flush, reset and perf saturation
module tb_branch_predictor_gshare;
  logic        CLK = 0, RST = 1, mode_gshare = 0, flush_all = 0;
  logic        upd_valid = 0, upd_taken = 0, upd_mispredict = 0;
  logic [11:0] IF_PC = 12'h013, upd_pc = '0, upd_target = '0;
  logic        pred_taken, p2_taken;
  logic [11:0] pred_target, p2_target;
  logic [15:0] perf_updates, perf_mispred;
  logic [1:0]  p2_updates, p2_mispred;
  int          n_chk = 0, n_pass = 0;
  always #5 CLK = ~CLK;
  branch_predictor_gshare dut (
    .CLK(CLK), .RST(RST), .mode_gshare(mode_gshare), .IF_PC(IF_PC),
    .pred_taken(pred_taken), .pred_target(pred_target), .flush_all(flush_all),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispredict(upd_mispredict),
    .perf_updates(perf_updates), .perf_mispred(perf_mispred)
  );
  branch_predictor_gshare #(.PERF_W(2)) dut2 (
    .CLK(CLK), .RST(RST), .mode_gshare(mode_gshare), .IF_PC(IF_PC),
    .pred_taken(p2_taken), .pred_target(p2_target), .flush_all(flush_all),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispredict(upd_mispredict),
    .perf_updates(p2_updates), .perf_mispred(p2_mispred)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic upd(input logic [11:0] pc, input logic t, input logic [11:0] tg,
                     input logic m, input logic f);
    @(negedge CLK);
    upd_valid = 1; upd_pc = pc; upd_taken = t; upd_target = tg; upd_mispredict = m; flush_all = f;
    @(negedge CLK);
    upd_valid = 0; flush_all = 0; upd_mispredict = 0;
  endtask
  task automatic look(input logic [11:0] pc);
    IF_PC = pc;
    #1;
  endtask
  task automatic hist4(input logic [3:0] h);
    for (int i = 3; i >= 0; i--) upd(12'h100, h[i], 12'h111, 0, 0);
  endtask
  initial begin
    #3;
    chk("rst_taken", pred_taken, 0);
    chk("rst_target", pred_target, 0);
    chk("rst_perf_u", perf_updates, 0);
    chk("rst_perf_m", perf_mispred, 0);
    @(negedge CLK); RST = 0;
    look(12'h013);
    chk("post_rst_taken", pred_taken, 0);
    upd(12'h013, 1, 12'h080, 0, 0);
    upd(12'h013, 1, 12'h080, 0, 0);
    look(12'h013);
    chk("bim_taken", pred_taken, 1);
    chk("bim_target", pred_target, 12'h080);
    look(12'h023);
    chk("tag_miss", pred_taken, 0);
    chk("tag_miss_tgt", pred_target, 0);
    look(12'h013);
    upd(12'h013, 0, 12'h000, 1, 0);
    look(12'h013);
    chk("nt1_still_taken", pred_taken, 1);
    upd(12'h013, 0, 12'h000, 0, 0);
    look(12'h013);
    chk("nt2_not_taken", pred_taken, 0);
    upd(12'h013, 0, 12'h000, 0, 0);
    hist4(4'b0101);
    mode_gshare = 1;
    look(12'h013);
    chk("gs_weak_nt", pred_taken, 0);
    upd(12'h013, 1, 12'h0A0, 1, 0);
    mode_gshare = 0;
    hist4(4'b0101);
    mode_gshare = 1;
    look(12'h013);
    chk("gs_taken", pred_taken, 1);
    chk("gs_target", pred_target, 12'h0A0);
    mode_gshare = 0;
    look(12'h013);
    chk("bim_sat0_nt", pred_taken, 0);
    chk("perf_u_14", perf_updates, 14);
    chk("perf_m_2", perf_mispred, 2);
    upd(12'h013, 1, 12'h0C0, 1, 1);
    look(12'h013);
    chk("flush_nt", pred_taken, 0);
    mode_gshare = 1;
    look(12'h013);
    chk("flush_gs_nt", pred_taken, 0);
    mode_gshare = 0;
    look(12'h100);
    chk("flush_idx0", pred_taken, 0);
    chk("flush_perf_u", perf_updates, 14);
    chk("flush_perf_m", perf_mispred, 2);
    upd(12'h013, 1, 12'h0C0, 0, 0);
    look(12'h013);
    chk("refill_weak", pred_taken, 0);
    upd(12'h013, 1, 12'h0C0, 0, 0);
    look(12'h013);
    chk("refill_taken", pred_taken, 1);
    chk("refill_target", pred_target, 12'h0C0);
    @(negedge CLK);
    upd_valid = 1; upd_pc = 12'h013; upd_taken = 1; upd_target = 12'h0C0; upd_mispredict = 1;
    #2 RST = 1;
    #1;
    chk("arst_taken", pred_taken, 0);
    chk("arst_target", pred_target, 0);
    chk("arst_perf_u", perf_updates, 0);
    chk("arst_perf_m", perf_mispred, 0);
    @(negedge CLK);
    chk("arst_hold_perf", perf_updates, 0);
    RST = 0; upd_mispredict = 0;
    @(negedge CLK);
    upd_valid = 0;
    chk("first_upd_perf", perf_updates, 1);
    for (int i = 0; i < 5; i++) upd(12'h200, 0, 12'h000, 1, 0);
    chk("perf_u_6", perf_updates, 6);
    chk("perf_m_5", perf_mispred, 5);
    chk("sat_perf_u", p2_updates, 3);
    chk("sat_perf_m", p2_mispred, 3);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
